exu_commit_flushctl: RTL

- Parametrised next-generation commit stage for the EXU.
- Accepts one ALU commit per cycle and resolves branch mispredicts and illegal-instruction exceptions.
- Drives a registered flush request to the IFU. The request is held stable until acknowledged.
- Keeps commit and mispredict counters, and an exception-PC register for the trap path.

---
 rtl/exu_commit_flushctl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/exu_commit_flushctl.sv
// EXU commit stage with flush control.
// Takes one ALU commit per cycle. An illegal instruction or a branch
// mispredict raises a registered flush request toward the IFU. That request
// is held until the IFU acknowledges it. The block also keeps the retire and
// mispredict counters and captures the PC of the last illegal instruction.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | accepting commits; no flush outstanding
//   FLUSH | flush request held toward IFU; commits stalled until acknowledge
module exu_commit_flushctl #(
    parameter int                 XLEN        = 32,
    parameter int                 PC_SIZE     = 32,
    parameter logic [PC_SIZE-1:0] TRAP_VEC    = PC_SIZE'(32'h0000_0080),
    parameter int                 INSTR_BYTES = 4,
    parameter int                 CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_i_valid,
    output logic               cmt_i_ready,
    input  logic [XLEN-1:0]    cmt_i_imm,
    input  logic               cmt_i_bjp,
    input  logic               cmt_i_bjp_prdt,
    input  logic               cmt_i_bjp_rslv,
    input  logic [PC_SIZE-1:0] cmt_i_pc,
    input  logic               cmt_i_ilegl,
    output logic               nonflush_cmt_ena,
    output logic               pipe_flush_req,
    input  logic               pipe_flush_ack,
    output logic [PC_SIZE-1:0] pipe_flush_add_op1,
    output logic [PC_SIZE-1:0] pipe_flush_add_op2,
    output logic               flush_pulse,
    output logic [1:0]         flush_cause,
    output logic [PC_SIZE-1:0] excp_pc,
    output logic [CNT_W-1:0]   cnt_cmt,
    output logic [CNT_W-1:0]   cnt_brchmis
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [PC_SIZE-1:0] INSTR_INC = PC_SIZE'(INSTR_BYTES);

    state_t             state;
    logic               hs;
    logic               ilg;
    logic               mis;
    logic [PC_SIZE-1:0] imm_pc;

    // Branch offset fitted to the PC width: truncate or zero-extend.
    generate
        if (XLEN >= PC_SIZE) begin : g_imm_trunc
            assign imm_pc = cmt_i_imm[PC_SIZE-1:0];
        end else begin : g_imm_zext
            assign imm_pc = {{(PC_SIZE-XLEN){1'b0}}, cmt_i_imm};
        end
    endgenerate

    // Ready is also gated by reset so that no commit is taken while reset is held.
    assign cmt_i_ready      = (state == IDLE) & ~rst;
    assign hs               = cmt_i_valid & cmt_i_ready;
    assign ilg              = cmt_i_ilegl;
    assign mis              = cmt_i_bjp & (cmt_i_bjp_prdt != cmt_i_bjp_rslv) & ~ilg;
    assign nonflush_cmt_ena = hs & ~ilg & ~mis;
    assign flush_pulse      = pipe_flush_req & pipe_flush_ack;

    // Flush FSM with registered request, target operands, cause and trap PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            pipe_flush_req     <= 1'b0;
            pipe_flush_add_op1 <= '0;
            pipe_flush_add_op2 <= '0;
            flush_cause        <= 2'b00;
            excp_pc            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs & (ilg | mis)) begin
                        state          <= FLUSH;
                        pipe_flush_req <= 1'b1;
                        if (ilg) begin
                            pipe_flush_add_op1 <= TRAP_VEC;
                            pipe_flush_add_op2 <= '0;
                            flush_cause        <= 2'b10;
                            excp_pc            <= cmt_i_pc;
                        end else begin
                            pipe_flush_add_op1 <= cmt_i_pc;
                            pipe_flush_add_op2 <= cmt_i_bjp_rslv ? imm_pc : INSTR_INC;
                            flush_cause        <= 2'b01;
                        end
                    end
                end
                FLUSH: begin
                    // The operands are left as they are. Only request and cause drop.
                    if (pipe_flush_ack) begin
                        state          <= IDLE;
                        pipe_flush_req <= 1'b0;
                        flush_cause    <= 2'b00;
                    end
                end
            endcase
        end
    end

    // Retire and mispredict counters. Mispredicted branches still retire. Both counters wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_cmt     <= '0;
            cnt_brchmis <= '0;
        end else begin
            if (hs & ~ilg) begin
                cnt_cmt <= cnt_cmt + 1'b1;
            end
            if (hs & mis) begin
                cnt_brchmis <= cnt_brchmis + 1'b1;
            end
        end
    end

endmodule
